// File: rtl/key_press_sequencer_pkg.sv
// rtl/key_press_sequencer_pkg.sv - shared constants, state encoding and key priority helper
//
// Purpose: definitions shared by the debounce FSM and the history/counter top.
// Contents: KEY_CODE_W, KEYS_RELEASED, state_e, lowest_active_key().
package key_press_sequencer_pkg;

  localparam int KEY_CODE_W = 4;
  localparam logic [3:0] KEYS_RELEASED = 4'b1111;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_e;

  // Index of the lowest active (zero) bit of an active-low key pattern.
  // Key 0 has the highest priority. An all-released pattern returns 0.
  function automatic logic [1:0] lowest_active_key(input logic [3:0] pat_n);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!pat_n[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/key_press_sequencer_debounce_fsm.sv
// rtl/key_press_sequencer_debounce_fsm.sv - key synchroniser, debounce FSM and press capture
//
// Purpose: synchronise raw active-low keys, debounce press and release, and
// issue one capture per accepted press.
// Ports:
//   clock_i          system clock
//   reset_i          synchronous active-high reset
//   key_n_i[3:0]     raw active-low keys, asynchronous to clock_i
//   capture_o        combinational strobe: a capture happens on the coming edge
//   capture_key_o    key index being captured (valid with capture_o)
//   press_valid_o    registered one-cycle pulse after each capture edge
//   press_key_o      registered key index of the last capture
//   busy_o           high while the FSM is not in IDLE
module key_debounce_fsm
  import key_press_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [3:0] key_n_i,
  output logic       capture_o,
  output logic [1:0] capture_key_o,
  output logic       press_valid_o,
  output logic [1:0] press_key_o,
  output logic       busy_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [3:0]       sync1_q, sync2_q;
  state_e           state_q, state_d;
  logic [3:0]       pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_valid_q;
  logic [1:0]       press_key_q;

  logic [3:0] s;
  assign s = sync2_q;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    cnt_d     = cnt_q;
    capture_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s != KEYS_RELEASED) begin
          pat_d   = s;
          cnt_d   = CNT_ONE;
          state_d = DEB_PRESS;
        end
      end
      DEB_PRESS: begin
        if (s == KEYS_RELEASED) begin
          state_d = IDLE;
        end else if (s != pat_q) begin
          // A different key set restarts the stability window.
          pat_d = s;
          cnt_d = CNT_ONE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = HELD;
          capture_o = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (s == KEYS_RELEASED) begin
          cnt_d   = CNT_ONE;
          state_d = DEB_REL;
        end
      end
      DEB_REL: begin
        if (s != KEYS_RELEASED) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign capture_key_o = lowest_active_key(pat_q);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q       <= KEYS_RELEASED;
      sync2_q       <= KEYS_RELEASED;
      state_q       <= IDLE;
      pat_q         <= KEYS_RELEASED;
      cnt_q         <= '0;
      press_valid_q <= 1'b0;
      press_key_q   <= 2'd0;
    end else begin
      sync1_q       <= key_n_i;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      pat_q         <= pat_d;
      cnt_q         <= cnt_d;
      press_valid_q <= capture_o;
      if (capture_o) press_key_q <= capture_key_o;
    end
  end

  assign press_valid_o = press_valid_q;
  assign press_key_o   = press_key_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: rtl/key_press_sequencer.sv
// rtl/key_press_sequencer.sv - debounced key events into a one-hot history and press counter
//
// Purpose: turn four bouncy active-low keys into one event per press, keep the
// last NUM_DIGITS keys (newest in slot 0) and count accepted presses.
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   key_n[3:0]   raw active-low keys
//   clear        synchronous clear of history and press count
//   digit_code   one-hot key code per slot, slot i at [4i+3:4i], 0 = empty
//   press_valid  one-cycle pulse per accepted press
//   press_key    binary index of the accepted key
//   press_count  accepted presses modulo 256
//   busy         high while the debounce FSM is not idle
module key_press_sequencer
  import key_press_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [3:0]                       key_n,
  input  logic                             clear,
  output logic [KEY_CODE_W*NUM_DIGITS-1:0] digit_code,
  output logic                             press_valid,
  output logic [1:0]                       press_key,
  output logic [7:0]                       press_count,
  output logic                             busy
);

  logic       capture;
  logic [1:0] capture_key;

  logic [KEY_CODE_W*NUM_DIGITS-1:0] digit_q, digit_d;
  logic [7:0]                       count_q, count_d;

  key_debounce_fsm #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clock_i      (clock),
    .reset_i      (reset),
    .key_n_i      (key_n),
    .capture_o    (capture),
    .capture_key_o(capture_key),
    .press_valid_o(press_valid),
    .press_key_o  (press_key),
    .busy_o       (busy)
  );

  // History and count move on the capture edge itself; clear wins over a
  // simultaneous capture, which is then lost from the history.
  always_comb begin
    digit_d = digit_q;
    count_d = count_q;
    if (clear) begin
      digit_d = '0;
      count_d = 8'd0;
    end else if (capture) begin
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
        digit_d[KEY_CODE_W*i +: KEY_CODE_W] = digit_q[KEY_CODE_W*(i-1) +: KEY_CODE_W];
      end
      digit_d[KEY_CODE_W-1:0] = 4'b0001 << capture_key;
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      digit_q <= '0;
      count_q <= 8'd0;
    end else begin
      digit_q <= digit_d;
      count_q <= count_d;
    end
  end

  assign digit_code  = digit_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_key_press_sequencer.sv
// tb/tb_key_press_sequencer.sv - self-checking bench for key_press_sequencer
module tb_key_press_sequencer;

  localparam int D  = 4;
  localparam int ND = 4;

  logic          clock;
  logic          reset;
  logic [3:0]    key_n;
  logic          clear;
  logic [4*ND-1:0] digit_code;
  logic          press_valid;
  logic [1:0]    press_key;
  logic [7:0]    press_count;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  key_press_sequencer #(
    .DEBOUNCE_CYCLES(D),
    .NUM_DIGITS     (ND)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .key_n      (key_n),
    .clear      (clear),
    .digit_code (digit_code),
    .press_valid(press_valid),
    .press_key  (press_key),
    .press_count(press_count),
    .busy       (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached (got timeout, required finish)");
    $fatal(1, "watchdog");
  end

  // Reference priority rule: lowest-index pressed (zero) key wins.
  function automatic int ref_key(input logic [3:0] p);
    for (int i = 0; i < 4; i++) if (p[i] == 1'b0) return i;
    return -1;
  endfunction

  function automatic logic [3:0] rand_active(input logic [3:0] avoid);
    logic [3:0] p;
    do p = 4'($urandom_range(0, 14)); while (p == avoid);
    return p;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    key_n = 4'b1111;
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int first_k;
    logic [1:0] k_at;
    reset = 1'b1;
    key_n = 4'b0000;
    clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (digit_code !== '0) begin n_err++; $display("FAIL reset_digit_code: got %h required 0", digit_code); end
    n_cmp++; if (press_valid !== 1'b0) begin n_err++; $display("FAIL reset_press_valid: got %b required 0", press_valid); end
    n_cmp++; if (press_key !== 2'd0) begin n_err++; $display("FAIL reset_press_key: got %0d required 0", press_key); end
    n_cmp++; if (press_count !== 8'd0) begin n_err++; $display("FAIL reset_press_count: got %0d required 0", press_count); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b required 0", busy); end
    reset = 1'b0;
    first_k = -1;
    k_at = 2'd0;
    for (int k = 1; k <= 15; k++) begin
      @(posedge clock); #1;
      if (press_valid === 1'b1 && first_k < 0) begin first_k = k; k_at = press_key; end
    end
    n_cmp++; if (first_k != D + 3) begin n_err++; $display("FAIL reset_release_latency: got edge %0d required %0d", first_k, D + 3); end
    n_cmp++; if (k_at !== 2'd0) begin n_err++; $display("FAIL reset_release_key: got %0d required 0", k_at); end
    key_n = 4'b1111;
    repeat (D + 6) @(posedge clock);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_idle_busy: got %b required 0", busy); end
  endtask

  task automatic test_clean_press();
    int first_k, pulses;
    do_reset();
    key_n = 4'b1011;
    first_k = -1;
    pulses = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (press_valid === 1'b1) begin
        pulses++;
        if (first_k < 0) first_k = k;
        n_cmp++; if (press_key !== 2'd2) begin n_err++; $display("FAIL clean_press_key: got %0d required 2", press_key); end
      end
    end
    n_cmp++; if (first_k != D + 3) begin n_err++; $display("FAIL clean_latency: got edge %0d required %0d", first_k, D + 3); end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL clean_pulses: got %0d required 1", pulses); end
    n_cmp++; if (digit_code[3:0] !== 4'b0100) begin n_err++; $display("FAIL clean_slot0: got %b required 0100", digit_code[3:0]); end
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL clean_count: got %0d required 1", press_count); end
    pulses = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clock); #1;
      if (press_valid === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL clean_hold_repeat: got %0d pulses required 0", pulses); end
    key_n = 4'b1111;
    repeat (D + 6) @(posedge clock);
  endtask

  task automatic test_bounce();
    int first_k, pulses;
    logic [1:0] k_at;
    do_reset();
    pulses = 0;
    for (int t = 0; t < 20; t++) begin
      key_n = ((t / 2) % 2 == 0) ? 4'b1110 : 4'b1111;
      @(posedge clock); #1;
      if (press_valid === 1'b1) pulses++;
    end
    key_n = 4'b1110;
    first_k = -1;
    k_at = 2'd3;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (press_valid === 1'b1) begin
        pulses++;
        if (first_k < 0) begin first_k = k; k_at = press_key; end
      end
    end
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL bounce_pulses: got %0d required 1", pulses); end
    n_cmp++; if (first_k != D + 3) begin n_err++; $display("FAIL bounce_latency: got edge %0d required %0d", first_k, D + 3); end
    n_cmp++; if (k_at !== 2'd0) begin n_err++; $display("FAIL bounce_key: got %0d required 0", k_at); end
    key_n = 4'b1111;
    repeat (D + 6) @(posedge clock);
  endtask

  task automatic test_priority_history();
    logic [1:0] k_first, k_second;
    do_reset();
    k_first = 2'd0;
    k_second = 2'd3;
    key_n = 4'b0111;
    for (int k = 0; k < D + 8; k++) begin
      @(posedge clock); #1;
      if (press_valid === 1'b1) k_first = press_key;
    end
    key_n = 4'b1111;
    repeat (D + 6) @(posedge clock);
    key_n = 4'b1001;
    for (int k = 0; k < D + 8; k++) begin
      @(posedge clock); #1;
      if (press_valid === 1'b1) k_second = press_key;
    end
    n_cmp++; if (k_first !== 2'd3) begin n_err++; $display("FAIL prio_first_key: got %0d required 3", k_first); end
    n_cmp++; if (k_second !== 2'd1) begin n_err++; $display("FAIL prio_second_key: got %0d required 1", k_second); end
    n_cmp++; if (digit_code !== 16'h0082) begin n_err++; $display("FAIL prio_history: got %h required 0082", digit_code); end
    n_cmp++; if (press_count !== 8'd2) begin n_err++; $display("FAIL prio_count: got %0d required 2", press_count); end
    key_n = 4'b1111;
    repeat (D + 6) @(posedge clock);
  endtask

  task automatic test_wrap();
    int pulses;
    do_reset();
    pulses = 0;
    for (int p = 0; p < 257; p++) begin
      key_n = 4'b1110;
      for (int k = 0; k < D + 3; k++) begin
        @(posedge clock); #1;
        if (press_valid === 1'b1) pulses++;
      end
      key_n = 4'b1111;
      for (int k = 0; k < D + 3; k++) begin
        @(posedge clock); #1;
        if (press_valid === 1'b1) pulses++;
      end
    end
    n_cmp++; if (pulses != 257) begin n_err++; $display("FAIL wrap_pulses: got %0d required 257", pulses); end
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL wrap_count: got %0d required 1", press_count); end
    n_cmp++; if (digit_code !== 16'h1111) begin n_err++; $display("FAIL wrap_history: got %h required 1111", digit_code); end
  endtask

  task automatic test_clear_collision();
    do_reset();
    key_n = 4'b1101;
    repeat (D + 6) @(posedge clock);
    key_n = 4'b1111;
    repeat (D + 6) @(posedge clock);
    #1;
    n_cmp++; if (press_count !== 8'd1) begin n_err++; $display("FAIL clear_pre_count: got %0d required 1", press_count); end
    key_n = 4'b1101;
    repeat (D + 2) @(posedge clock);
    #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    n_cmp++; if (press_valid !== 1'b1) begin n_err++; $display("FAIL clear_valid: got %b required 1", press_valid); end
    n_cmp++; if (press_key !== 2'd1) begin n_err++; $display("FAIL clear_key: got %0d required 1", press_key); end
    n_cmp++; if (digit_code !== '0) begin n_err++; $display("FAIL clear_history: got %h required 0", digit_code); end
    n_cmp++; if (press_count !== 8'd0) begin n_err++; $display("FAIL clear_count: got %0d required 0", press_count); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy: got %b required 1", busy); end
    key_n = 4'b1111;
    repeat (D + 6) @(posedge clock);
  endtask

  // Random press episodes: short bounces, a stable press, wiggles while held,
  // release bounces, then a long release. Each episode yields exactly one event
  // D+2 edges after the first sample of its stable press pattern.
  task automatic test_random();
    logic [3:0] stim[$];
    int ev_edge[$];
    int ev_key[$];
    logic [3:0] prev, p;
    int len, ev;
    int m_count;
    logic [3:0] m_hist[ND];
    logic [4*ND-1:0] exp_dc;
    bit exp_v;

    prev = 4'b1111;
    for (int e = 0; e < 14; e++) begin
      for (int b = 0; b < int'($urandom_range(0, 3)); b++) begin
        if (prev != 4'b1111 && $urandom_range(0, 1) == 1) p = 4'b1111;
        else p = rand_active(prev);
        len = (p == 4'b1111) ? int'($urandom_range(1, 3)) : int'($urandom_range(1, D));
        for (int i = 0; i < len; i++) stim.push_back(p);
        prev = p;
      end
      p = rand_active(prev);
      ev_edge.push_back(stim.size() + D + 2);
      ev_key.push_back(ref_key(p));
      len = D + 2 + int'($urandom_range(0, 5));
      for (int i = 0; i < len; i++) stim.push_back(p);
      prev = p;
      for (int h = 0; h < int'($urandom_range(0, 3)); h++) begin
        p = rand_active(prev);
        len = int'($urandom_range(1, 6));
        for (int i = 0; i < len; i++) stim.push_back(p);
        prev = p;
      end
      for (int r = 0; r < int'($urandom_range(0, 3)); r++) begin
        len = int'($urandom_range(1, D));
        for (int i = 0; i < len; i++) stim.push_back(4'b1111);
        p = rand_active(4'b1111);
        len = int'($urandom_range(1, 3));
        for (int i = 0; i < len; i++) stim.push_back(p);
        prev = p;
      end
      len = D + 3 + int'($urandom_range(0, 3));
      for (int i = 0; i < len; i++) stim.push_back(4'b1111);
      prev = 4'b1111;
    end
    for (int i = 0; i < 10; i++) stim.push_back(4'b1111);

    do_reset();
    m_count = 0;
    for (int i = 0; i < ND; i++) m_hist[i] = 4'b0000;
    ev = 0;
    for (int k = 0; k < stim.size(); k++) begin
      key_n = stim[k];
      @(posedge clock); #1;
      exp_v = (ev < ev_edge.size()) && (ev_edge[ev] == k);
      n_cmp++;
      if (press_valid !== exp_v) begin
        n_err++;
        $display("FAIL rand_valid@%0d: got %b required %b", k, press_valid, exp_v);
      end
      if (exp_v) begin
        for (int i = ND - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = 4'(1 << ev_key[ev]);
        m_count = (m_count + 1) % 256;
        for (int i = 0; i < ND; i++) exp_dc[4*i +: 4] = m_hist[i];
        n_cmp++;
        if (press_key !== 2'(ev_key[ev])) begin
          n_err++;
          $display("FAIL rand_key@%0d: got %0d required %0d", k, press_key, ev_key[ev]);
        end
        n_cmp++;
        if (digit_code !== exp_dc) begin
          n_err++;
          $display("FAIL rand_history@%0d: got %h required %h", k, digit_code, exp_dc);
        end
        n_cmp++;
        if (press_count !== 8'(m_count)) begin
          n_err++;
          $display("FAIL rand_count@%0d: got %0d required %0d", k, press_count, m_count);
        end
        ev++;
      end
    end
    n_cmp++;
    if (ev != ev_edge.size()) begin
      n_err++;
      $display("FAIL rand_events: got %0d required %0d", ev, ev_edge.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    key_n = 4'b1111;
    clear = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_priority_history();
    test_wrap();
    test_clear_collision();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
